// File: rtl/rnn_mem_server.sv
// rtl/rnn_mem_server.sv - weight/bias/sequence memory server for an RNN core
//
// Ports:
//   clk_i, reset_i            clock, asynchronous active-high reset
//   busy_i                    RNN run in progress
//   i_en_i / idata_o          input-vector feeder (X store, one vector per request)
//   mce_i, msel_i, maddr_i    RNN memory access: region select and word address
//   mdata_w_i / mdata_r_o     RNN output write data (msel=101) / read data (1-cycle latency)
//   load_en_i, load_sel_i,
//   load_addr_i, load_data_i  host preload port (only while the RNN is idle)
//   rd_addr_i / rd_data_o     host readback of the output store Y (1-cycle latency)
//   wr_count_o, done_o, err_o status: accepted output writes, run finished, sticky error
module rnn_mem_server #(
    parameter int L_INPUT  = 32,
    parameter int L_HIDDEN = 64,
    parameter int L_TIME   = 200,
    parameter int SEQ_LEN  = 200
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               busy_i,
    input  logic               i_en_i,
    output logic [L_INPUT-1:0] idata_o,
    input  logic               mce_i,
    input  logic [2:0]         msel_i,
    input  logic [16:0]        maddr_i,
    input  logic [19:0]        mdata_w_i,
    output logic [19:0]        mdata_r_o,
    input  logic               load_en_i,
    input  logic [2:0]         load_sel_i,
    input  logic [11:0]        load_addr_i,
    input  logic [31:0]        load_data_i,
    input  logic [13:0]        rd_addr_i,
    output logic [19:0]        rd_data_o,
    output logic [13:0]        wr_count_o,
    output logic               done_o,
    output logic               err_o
);
    localparam int L_IH  = L_INPUT * L_HIDDEN;
    localparam int L_HH  = L_HIDDEN * L_HIDDEN;
    localparam int L_HT  = L_HIDDEN * L_TIME;
    localparam int AW_IH = $clog2(L_IH);
    localparam int AW_B  = $clog2(L_HIDDEN);
    localparam int AW_HH = $clog2(L_HH);
    localparam int AW_HT = $clog2(L_HT);
    localparam int AW_X  = $clog2(L_TIME);
    localparam int IW    = $clog2(L_TIME + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    logic [19:0]        w_ih [L_IH];
    logic [19:0]        b_ih [L_HIDDEN];
    logic [19:0]        w_hh [L_HH];
    logic [19:0]        b_hh [L_HIDDEN];
    logic [19:0]        y_mem[L_HT];
    logic [L_INPUT-1:0] x_mem[L_TIME];

    state_t             state_q, state_d;
    logic               busy_q;
    logic [IW-1:0]      idx_q, idx_d;
    logic [L_INPUT-1:0] idata_q, idata_d;
    logic [19:0]        mdata_r_q, mdata_r_d;
    logic [19:0]        rd_data_q, rd_data_d;
    logic [13:0]        wr_count_q, wr_count_d;
    logic               err_q, err_d;
    logic               err_set, y_we, ld_we, ld_in_range, enter_run;

    // RNN access decode: read mux, output-store write strobe, error detection
    always_comb begin
        mdata_r_d = mdata_r_q;
        y_we      = 1'b0;
        err_set   = 1'b0;
        if (mce_i) begin
            case (msel_i)
                3'b000: if (32'(maddr_i) < L_IH) mdata_r_d = w_ih[maddr_i[AW_IH-1:0]];
                        else begin mdata_r_d = '0; err_set = 1'b1; end
                3'b001: if (32'(maddr_i) < L_HIDDEN) mdata_r_d = b_ih[maddr_i[AW_B-1:0]];
                        else begin mdata_r_d = '0; err_set = 1'b1; end
                3'b010: if (32'(maddr_i) < L_HH) mdata_r_d = w_hh[maddr_i[AW_HH-1:0]];
                        else begin mdata_r_d = '0; err_set = 1'b1; end
                3'b011: if (32'(maddr_i) < L_HIDDEN) mdata_r_d = b_hh[maddr_i[AW_B-1:0]];
                        else begin mdata_r_d = '0; err_set = 1'b1; end
                3'b100: mdata_r_d = 20'(SEQ_LEN);
                3'b101: if (32'(maddr_i) < L_HT) y_we = 1'b1;
                        else err_set = 1'b1;
                default: err_set = 1'b1;
            endcase
        end

        // Host preload: selects 100/101/111 are silently ignored
        ld_we       = 1'b0;
        ld_in_range = 1'b0;
        case (load_sel_i)
            3'b000:  ld_in_range = 32'(load_addr_i) < L_IH;
            3'b001:  ld_in_range = 32'(load_addr_i) < L_HIDDEN;
            3'b010:  ld_in_range = 32'(load_addr_i) < L_HH;
            3'b011:  ld_in_range = 32'(load_addr_i) < L_HIDDEN;
            3'b110:  ld_in_range = 32'(load_addr_i) < L_TIME;
            default: ld_in_range = 1'b0;
        endcase
        if (load_en_i && (load_sel_i[2:0] <= 3'b011 || load_sel_i == 3'b110)) begin
            if (!busy_i && ld_in_range) ld_we = 1'b1;
            else                        err_set = 1'b1;
        end
    end

    // Run control and feeder
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (busy_i && !busy_q) state_d = S_RUN;
            S_RUN:   if (!busy_i && busy_q) state_d = S_DONE;
            S_DONE:  if (busy_i && !busy_q) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
        enter_run = (state_d == S_RUN) && (state_q != S_RUN);

        idx_d   = idx_q;
        idata_d = idata_q;
        if (enter_run) begin
            idx_d = '0;
        end else if (i_en_i && busy_i && 32'(idx_q) < L_TIME) begin
            idata_d = x_mem[idx_q[AW_X-1:0]];
            idx_d   = idx_q + IW'(1);
        end

        wr_count_d = wr_count_q;
        if (enter_run)                           wr_count_d = '0;
        else if (y_we && 32'(wr_count_q) < L_HT) wr_count_d = wr_count_q + 14'd1;

        err_d = enter_run ? 1'b0 : (err_q | err_set);

        rd_data_d = (32'(rd_addr_i) < L_HT) ? y_mem[rd_addr_i[AW_HT-1:0]] : 20'd0;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            idx_q      <= '0;
            idata_q    <= '0;
            mdata_r_q  <= '0;
            rd_data_q  <= '0;
            wr_count_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_i;
            idx_q      <= idx_d;
            idata_q    <= idata_d;
            mdata_r_q  <= mdata_r_d;
            rd_data_q  <= rd_data_d;
            wr_count_q <= wr_count_d;
            err_q      <= err_d;
        end
    end

    // Storage arrays are never reset; reads above see pre-edge contents
    always_ff @(posedge clk_i) begin
        if (ld_we) begin
            case (load_sel_i)
                3'b000:  w_ih[load_addr_i[AW_IH-1:0]] <= load_data_i[19:0];
                3'b001:  b_ih[load_addr_i[AW_B-1:0]]  <= load_data_i[19:0];
                3'b010:  w_hh[load_addr_i[AW_HH-1:0]] <= load_data_i[19:0];
                3'b011:  b_hh[load_addr_i[AW_B-1:0]]  <= load_data_i[19:0];
                3'b110:  x_mem[load_addr_i[AW_X-1:0]] <= load_data_i[L_INPUT-1:0];
                default: ;
            endcase
        end
        if (y_we) y_mem[maddr_i[AW_HT-1:0]] <= mdata_w_i;
    end

    assign idata_o    = idata_q;
    assign mdata_r_o  = mdata_r_q;
    assign rd_data_o  = rd_data_q;
    assign wr_count_o = wr_count_q;
    assign done_o     = (state_q == S_DONE);
    assign err_o      = err_q;
endmodule

// File: tb/tb_rnn_mem_server.sv
// tb/tb_rnn_mem_server.sv - directed scoreboard bench for rnn_mem_server
module tb_rnn_mem_server;
    logic        clk = 1'b0;
    logic        reset, busy, i_en, mce, load_en;
    logic [2:0]  msel, load_sel;
    logic [16:0] maddr;
    logic [19:0] mdata_w, mdata_r, rd_data;
    logic [11:0] load_addr;
    logic [31:0] load_data, idata;
    logic [13:0] rd_addr, wr_count;
    logic        done, err;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    rnn_mem_server dut (
        .clk_i(clk), .reset_i(reset), .busy_i(busy), .i_en_i(i_en), .idata_o(idata),
        .mce_i(mce), .msel_i(msel), .maddr_i(maddr), .mdata_w_i(mdata_w), .mdata_r_o(mdata_r),
        .load_en_i(load_en), .load_sel_i(load_sel), .load_addr_i(load_addr), .load_data_i(load_data),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data), .wr_count_o(wr_count), .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] e);
        tag_q.push_back(tag);
        exp_q.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] act);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty: observed=%h expected=queued value", act);
        end else begin
            chk(tag_q.pop_front(), act, exp_q.pop_front());
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] sel, input logic [11:0] addr, input logic [31:0] data);
        load_en = 1'b1; load_sel = sel; load_addr = addr; load_data = data;
        tick();
        load_en = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [2:0] sel, input logic [16:0] addr, input logic [19:0] e);
        mce = 1'b1; msel = sel; maddr = addr;
        push(tag, {12'd0, e});
        tick();
        mce = 1'b0;
        pop_chk({12'd0, mdata_r});
    endtask

    task automatic wr(input logic [16:0] addr, input logic [19:0] data);
        mce = 1'b1; msel = 3'b101; maddr = addr; mdata_w = data;
        tick();
        mce = 1'b0;
    endtask

    task automatic host_rd(input string tag, input logic [13:0] addr, input logic [19:0] e);
        rd_addr = addr;
        push(tag, {12'd0, e});
        tick();
        pop_chk({12'd0, rd_data});
    endtask

    task automatic check_all_zero(input string pfx);
        chk({pfx, "_idata"}, idata, 32'd0);
        chk({pfx, "_mdata_r"}, {12'd0, mdata_r}, 32'd0);
        chk({pfx, "_rd_data"}, {12'd0, rd_data}, 32'd0);
        chk({pfx, "_wr_count"}, {18'd0, wr_count}, 32'd0);
        chk({pfx, "_done"}, {31'd0, done}, 32'd0);
        chk({pfx, "_err"}, {31'd0, err}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; busy = 1'b0; i_en = 1'b0; mce = 1'b0; load_en = 1'b0;
        msel = 3'b000; load_sel = 3'b000; maddr = '0; mdata_w = '0;
        load_addr = '0; load_data = '0; rd_addr = '0;
        #1;
        check_all_zero("reset");
        #20;
        reset = 1'b0;
        tick();

        // Preload while idle
        load(3'b000, 12'd5, 32'h0001_2345);
        load(3'b001, 12'd3, 32'hFFF0_00B1);
        load(3'b010, 12'd4095, 32'h0000_ABCD);
        load(3'b011, 12'd63, 32'h000F_FFFF);
        for (int i = 0; i < 200; i++) load(3'b110, 12'(i), 32'(i));
        chk("load_ok_err", {31'd0, err}, 32'd0);
        load(3'b110, 12'd200, 32'hDEAD_BEEF);
        chk("load_x_oob_err", {31'd0, err}, 32'd1);

        // First run: entry clears err
        busy = 1'b1;
        tick();
        chk("run1_err_clr", {31'd0, err}, 32'd0);
        chk("run1_done", {31'd0, done}, 32'd0);
        rd("rd_wih5", 3'b000, 17'd5, 20'h12345);
        push("hold_mce0", 32'h0001_2345);
        tick();
        pop_chk({12'd0, mdata_r});
        rd("rd_seqlen", 3'b100, 17'd5, 20'h000C8);
        rd("rd_bih3", 3'b001, 17'd3, 20'h000B1);
        rd("rd_whh4095", 3'b010, 17'd4095, 20'h0ABCD);
        rd("rd_bhh63", 3'b011, 17'd63, 20'hFFFFF);
        chk("rd_ok_err", {31'd0, err}, 32'd0);

        // Feeder: 200 vectors then hold at the last one
        i_en = 1'b1;
        for (int k = 0; k < 210; k++) begin
            push($sformatf("feed_%0d", k), (k < 200) ? 32'(k) : 32'd199);
            tick();
            pop_chk(idata);
        end
        i_en = 1'b0;

        rd("rd_bih_oob", 3'b001, 17'd64, 20'h0);
        chk("rd_oob_err", {31'd0, err}, 32'd1);

        // Second run: full output write sweep
        busy = 1'b0;
        tick();
        chk("run1_done_set", {31'd0, done}, 32'd1);
        busy = 1'b1;
        tick();
        chk("run2_err_clr", {31'd0, err}, 32'd0);
        chk("run2_wr_count_clr", {18'd0, wr_count}, 32'd0);
        mce = 1'b1; msel = 3'b101;
        for (int k = 0; k < 12800; k++) begin
            maddr = 17'(k); mdata_w = 20'(k + 1);
            tick();
        end
        mce = 1'b0;
        chk("wr_count_full", {18'd0, wr_count}, 32'd12800);
        wr(17'd0, 20'd1);
        chk("wr_count_sat", {18'd0, wr_count}, 32'd12800);
        chk("wr_sat_err", {31'd0, err}, 32'd0);
        wr(17'd12800, 20'hABCDE);
        chk("wr_oob_err", {31'd0, err}, 32'd1);
        chk("wr_oob_count", {18'd0, wr_count}, 32'd12800);
        busy = 1'b0;
        tick();
        chk("run2_done", {31'd0, done}, 32'd1);
        chk("run2_done_count", {18'd0, wr_count}, 32'd12800);
        host_rd("y100", 14'd100, 20'h00065);
        host_rd("y0", 14'd0, 20'h00001);
        host_rd("y12799", 14'd12799, 20'd12800);
        host_rd("y_oob", 14'd12800, 20'h0);
        chk("y_oob_err_kept", {31'd0, err}, 32'd1);

        // Third run: load while busy is refused
        busy = 1'b1;
        tick();
        chk("run3_err_clr", {31'd0, err}, 32'd0);
        load(3'b000, 12'd5, 32'h000A_BCDE);
        chk("busy_load_err", {31'd0, err}, 32'd1);
        rd("busy_load_unchanged", 3'b000, 17'd5, 20'h12345);

        // Fourth run: illegal select
        busy = 1'b0;
        tick();
        busy = 1'b1;
        tick();
        chk("run4_err_clr", {31'd0, err}, 32'd0);
        mce = 1'b1; msel = 3'b111; maddr = 17'd0;
        tick();
        mce = 1'b0;
        chk("msel111_err", {31'd0, err}, 32'd1);
        chk("msel111_count", {18'd0, wr_count}, 32'd0);
        chk("msel111_hold", {12'd0, mdata_r}, 32'h0001_2345);

        // Same-edge load and read returns old data
        busy = 1'b0;
        tick();
        load(3'b000, 12'd7, 32'h0001_1111);
        load_en = 1'b1; load_sel = 3'b000; load_addr = 12'd7; load_data = 32'h0002_2222;
        mce = 1'b1; msel = 3'b000; maddr = 17'd7;
        push("same_edge_old", 32'h0001_1111);
        tick();
        load_en = 1'b0; mce = 1'b0;
        pop_chk({12'd0, mdata_r});
        rd("same_edge_new", 3'b000, 17'd7, 20'h22222);

        // Reset in the middle of a run
        busy = 1'b1;
        tick();
        i_en = 1'b1;
        tick(); tick(); tick();
        i_en = 1'b0;
        chk("midrun_idata", idata, 32'd2);
        wr(17'd3, 20'd9);
        chk("midrun_count", {18'd0, wr_count}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check_all_zero("midrun_reset");
        #1 reset = 1'b0;
        tick();
        chk("post_reset_run_done", {31'd0, done}, 32'd0);
        busy = 1'b0;
        tick();
        chk("post_reset_done", {31'd0, done}, 32'd1);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rnn_mem_server.md
RNN_MEM_SERVER -- requirements
Module: rnn_mem_server

Interface
REQ-001 Parameters: L_INPUT 32 input vector width; L_HIDDEN 64 hidden size; L_TIME 200 timesteps; SEQ_LEN 200 value returned for msel=100.
REQ-002 Derived: L_IH=L_INPUT*L_HIDDEN, L_HH=L_HIDDEN*L_HIDDEN, L_HT=L_HIDDEN*L_TIME.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 busy  input  1  RNN busy; high during a run.
REQ-006 i_en  input  1  RNN request for next input vector.
REQ-007 idata  output  L_INPUT  input vector to RNN.
REQ-008 mce  input  1  RNN memory access enable.
REQ-009 msel  input  3  region select: 000 W_IH, 001 B_IH, 010 W_HH, 011 B_HH, 100 SEQ_LEN, 101 output write, 110/111 illegal.
REQ-010 maddr  input  17  word address within region.
REQ-011 mdata_w  input  20  output data from RNN (msel=101).
REQ-012 mdata_r  output  20  read data to RNN.
REQ-013 load_en, load_sel[2:0], load_addr[11:0], load_data[31:0]  inputs  host preload port; load_sel 000-011 as msel, 110 = X input store (32-bit); others ignored.
REQ-014 rd_addr[13:0] input, rd_data[19:0] output  host readback of output store Y.
REQ-015 wr_count[13:0], done, err  outputs  status.

Function
REQ-016 Storage: W_IH[L_IH], B_IH[L_HIDDEN], W_HH[L_HH], B_HH[L_HIDDEN], Y[L_HT] 20-bit words; X[L_TIME] L_INPUT-bit words.
REQ-017 Read: mce=1, msel 000-011 at edge N -> mdata_r = region[maddr] after edge N (1-cycle latency); msel=100 -> mdata_r = SEQ_LEN zero-extended to 20 bits.
REQ-018 mce=0 or msel 101/110/111: mdata_r holds previous value.
REQ-019 Read with maddr >= region size: mdata_r=0, err set.
REQ-020 Write: mce=1, msel=101, maddr<L_HT -> Y[maddr]=mdata_w at edge; wr_count+1, saturating at L_HT.
REQ-021 Write with maddr>=L_HT: dropped, wr_count unchanged, err set; msel 110/111 with mce=1: no action, err set.
REQ-022 Load accepted only when busy=0 and load_addr within region; load_data[19:0] used for 20-bit regions; otherwise dropped and err set.
REQ-023 Same-edge load and read of one location: read returns old data.
REQ-024 Feeder: index idx 0..L_TIME; on edge with i_en=1, busy=1, idx<L_TIME -> idata=X[idx], idx+1; idx=L_TIME -> idata holds, idx holds; i_en=0 -> idata holds.
REQ-025 FSM IDLE/RUN/DONE: IDLE->RUN on busy 0->1; RUN->DONE on busy 1->0; DONE->RUN on busy 0->1.
REQ-026 Entering RUN clears idx, wr_count, err (same edge); Y not cleared.
REQ-027 done=1 only in DONE.
REQ-028 rd_data = Y[rd_addr] one cycle after rd_addr sampled; rd_addr>=L_HT -> rd_data=0, no err.
REQ-029 err sticky until reset or RUN entry.

Reset
REQ-030 Reset asserted: state IDLE, idx=0, idata=0, mdata_r=0, rd_data=0, wr_count=0, done=0, err=0, immediately without clock.
REQ-031 Storage arrays not reset; reset mid-run abandons run, next busy rise starts fresh RUN.

Verification
REQ-032 Preload W_IH[5]=0x12345, busy=1, mce=1 msel=000 maddr=5 -> mdata_r=0x12345 next cycle; msel=100 -> 0x000C8.
REQ-033 Preload X[0..199]=i, busy=1, i_en high 210 cycles -> idata 0..199 in order, then holds 199; idx stops at 200.
REQ-034 12800 writes msel=101 maddr=k data=k+1 then busy low -> done=1, wr_count=12800, rd_addr=100 gives rd_data=0x00065.
REQ-035 mce=1 msel=101 maddr=12800, then msel=111 -> err=1, wr_count unchanged; next busy rise clears err.
REQ-036 load_en while busy=1 -> store unchanged, err=1; reset pulse mid-run -> all outputs 0, state IDLE asynchronously.
